// File: rtl/grid_pixel_streamer.sv
// Streams the 1-bit canvas as intensity bytes in row-major order over valid/ready.
// Optional macro PIXEL_COUNT_EN enables the drawn-pixel counter on ones_count.
module grid_pixel_streamer #(
  parameter int               GRID_SIZE = 28,
  parameter int               ADDR_W    = 10,
  parameter int               DATA_W    = 8,
  parameter logic [DATA_W-1:0] ON_VALUE  = 8'd255,
  parameter logic [DATA_W-1:0] OFF_VALUE = 8'd0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ones_count
);

  localparam int NUM_PIXELS = GRID_SIZE * GRID_SIZE;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_SEND, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_out_index;
  logic                r_last;
  logic                r_busy;
  logic                r_done;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_out_index <= '0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort && r_state != S_IDLE) begin
      // abort outranks any handshake landing on the same edge
      r_state <= S_IDLE;
      r_rd_en <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start && !abort) begin
            r_state   <= S_FETCH;
            r_idx     <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_FETCH: begin
          r_rd_en <= 1'b0;
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_data      <= rd_data ? ON_VALUE : OFF_VALUE;
          r_out_index <= r_idx;
          r_last      <= (r_idx == LAST_IDX);
          r_valid     <= 1'b1;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (r_valid && out_ready) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_rd_addr <= r_idx + 1'b1;
              r_rd_en   <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PIXEL_COUNT_EN
  logic              r_bit;
  logic [ADDR_W-1:0] r_ones;
  logic              w_start_acc;
  logic              w_accept;

  assign w_start_acc = (r_state == S_IDLE) && start && !abort;
  assign w_accept    = (r_state == S_SEND) && r_valid && out_ready && !abort;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_bit  <= 1'b0;
      r_ones <= '0;
    end else begin
      if (r_state == S_CAPTURE) r_bit <= rd_data;
      if (w_start_acc)
        r_ones <= '0;
      else if (w_accept && r_bit)
        r_ones <= r_ones + 1'b1;
    end
  end

  assign ones_count = r_ones;
`else
  assign ones_count = '0;
`endif

  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_index = r_out_index;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_grid_pixel_streamer.sv
// Directed bench for grid_pixel_streamer with a beat-level scoreboard of the canvas.
module tb_grid_pixel_streamer;
  localparam int N = 784;

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, abort = 1'b0, rd_data = 1'b0, out_ready = 1'b1;
  logic       rd_en, out_valid, out_last, busy, done;
  logic [9:0] rd_addr, out_index, ones_count;
  logic [7:0] out_data;

  bit mem [0:N-1];

  int n_vec = 0, n_bad = 0;
  int scan_gen = 0;
  int exp_idx = 0, exp_ones = 0, done_pulses = 0, cap29 = -1;

  grid_pixel_streamer dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
    .ones_count(ones_count)
  );

  always #5 clk = ~clk;

  // synchronous 1-bit canvas memory
  always @(posedge clk) if (rd_en && int'(rd_addr) < N) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] count_if_en(input int c);
`ifdef PIXEL_COUNT_EN
    return c;
`else
    return (c == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  // scoreboard: the k-th accepted beat of a scan must be canvas pixel k
  initial begin : cmp
    int         last_gen;
    bit         hold;
    logic [7:0] hold_data;
    logic [9:0] hold_idx;
    last_gen = 0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (scan_gen != last_gen) begin
        last_gen = scan_gen;
        exp_idx = 0;
        exp_ones = 0;
        done_pulses = 0;
      end
      if (reset) begin
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, hold_data);
          chk("hold_index", out_index, hold_idx);
        end
        if (out_valid) chk("busy_with_valid", busy, 1);
        if (out_valid && out_ready && !abort) begin
          chk("beat_index", out_index, exp_idx);
          if (exp_idx < N) begin
            chk("beat_data", out_data, mem[exp_idx] ? 255 : 0);
            chk("beat_last", out_last, exp_idx == N - 1);
            if (exp_idx == 29) cap29 = out_data;
            if (mem[exp_idx]) exp_ones++;
          end
          exp_idx++;
        end
        if (done) begin
          done_pulses++;
          chk("done_after_all_beats", exp_idx, N);
          chk("done_ones_count", ones_count, count_if_en(exp_ones));
          chk("done_busy", busy, 0);
          chk("done_valid", out_valid, 0);
        end
        hold = out_valid && !out_ready && !abort;
        hold_data = out_data;
        hold_idx = out_index;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    scan_gen++;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n counts cycles after the start edge; n_done = cycle done is seen, -2 on abort/reset exit
  task automatic run_scan(input int n0, input int bp_beat, input int ab_beat,
                          input int rs_beat, input bit stray, output int n_done);
    int n;
    int bp_left;
    bit bp_seen;
    n = n0;
    bp_left = 0;
    bp_seen = 0;
    n_done = -1;
    while (n < 3000) begin
      if (done) begin
        n_done = n;
        if (stray) begin
          start = 1'b1;
          tick();
          start = 1'b0;
        end
        return;
      end
      if (out_valid && int'(out_index) == ab_beat) begin
        out_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_done = -2;
        return;
      end
      if (out_valid && int'(out_index) == rs_beat) begin
        reset = 1'b1;
        tick();
        n_done = -2;
        return;
      end
      if (out_valid && int'(out_index) == bp_beat && !bp_seen) begin
        bp_seen = 1;
        bp_left = 10;
      end
      out_ready = (bp_left == 0);
      if (bp_left > 0) bp_left--;
      start = stray && (n == 500);
      tick();
      n++;
    end
    chk("scan_timeout", 1, 0);
  endtask

  initial begin
    int nd;
    foreach (mem[i]) mem[i] = 0;

    tick();
    tick();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ones_count", ones_count, 0);
    reset = 1'b0;
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", busy, 0);

    // empty grid with latency pins
    pulse_start();
    chk("lat_busy_k1", busy, 1);
    chk("lat_rd_en_k1", rd_en, 1);
    chk("lat_rd_addr_k1", rd_addr, 0);
    tick();
    chk("lat_rd_en_k2", rd_en, 0);
    chk("lat_valid_k2", out_valid, 0);
    tick();
    chk("lat_valid_k3", out_valid, 1);
    chk("lat_index_k3", out_index, 0);
    run_scan(3, -1, -1, -1, 0, nd);
    chk("empty_done_cycle", nd, 2353);
    tick();
    chk("empty_done_one_cycle", done, 0);
    chk("empty_busy_after", busy, 0);
    chk("empty_ones", ones_count, 0);
    chk("empty_done_pulses", done_pulses, 1);

    // sparse pattern
    mem[0] = 1;
    mem[29] = 1;
    mem[783] = 1;
    pulse_start();
    run_scan(1, -1, -1, -1, 0, nd);
    chk("pattern_done_cycle", nd, 2353);
    chk("pattern_pixel29", cap29, 255);
    chk("pattern_model_ones", exp_ones, 3);
`ifdef PIXEL_COUNT_EN
    chk("pattern_ones_count", ones_count, 3);
`else
    chk("pattern_ones_count", ones_count, 0);
`endif
    tick();

    // backpressure on beat 5
    pulse_start();
    run_scan(1, 5, -1, -1, 0, nd);
    chk("bp_done_cycle", nd, 2363);
    chk("bp_beats", exp_idx, N);
    out_ready = 1'b1;
    tick();

    // abort on beat 100 while handshaking
    pulse_start();
    run_scan(1, -1, 100, -1, 0, nd);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_beats", exp_idx, 100);
`ifdef PIXEL_COUNT_EN
    chk("abort_ones_hold", ones_count, 2);
`else
    chk("abort_ones_hold", ones_count, 0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    chk("abort_done_pulses", done_pulses, 0);
    pulse_start();
    run_scan(1, -1, -1, -1, 0, nd);
    chk("restart_done_cycle", nd, 2353);
    tick();

    // stray starts mid-scan and in DONE
    pulse_start();
    run_scan(1, -1, -1, -1, 1, nd);
    chk("stray_done_cycle", nd, 2353);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stray_idle_busy", busy, 0);
      chk("stray_idle_valid", out_valid, 0);
    end
    chk("stray_done_pulses", done_pulses, 1);

    // reset mid-scan at beat 400
    pulse_start();
    run_scan(1, -1, -1, 400, 0, nd);
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rd_en", rd_en, 0);
    chk("rstmid_index", out_index, 0);
    chk("rstmid_data", out_data, 0);
    chk("rstmid_ones", ones_count, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("rstmid_idle_rd_en", rd_en, 0);
    chk("rstmid_idle_busy", busy, 0);
    chk("rstmid_idle_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/grid_pixel_streamer.md
Name: grid_pixel_streamer

Overview:
- Downstream consumer of the 28x28 drawing canvas.
- On a start request, it reads the 1-bit pixel memory in row-major order, index = y*GRID_SIZE + x, through a synchronous read port.
- Each pixel becomes an intensity byte and is streamed to the neural-network input stage over a valid/ready handshake.
- Asserts busy while scanning so the drawing logic can freeze edits.

Parameters:
- GRID_SIZE, 28: grid edge length; NUM_PIXELS = GRID_SIZE*GRID_SIZE (784) is derived, not overridable.
- ADDR_W, 10: pixel index / read-address width; must satisfy 2^ADDR_W >= NUM_PIXELS.
- DATA_W, 8: output intensity width.
- ON_VALUE, 8'd255: intensity emitted for a drawn pixel (memory bit 1).
- OFF_VALUE, 8'd0: intensity emitted for a blank pixel (memory bit 0).

Ports:
- CLOCK_50  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a scan; sampled only in IDLE.
- abort  in  1  synchronous abort of an in-progress scan.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory read address.
- rd_data  in  1  pixel bit; valid exactly one cycle after the rd_en cycle.
- out_valid  out  1  out_data / out_index / out_last are valid.
- out_ready  in  1  downstream accepts when high with out_valid.
- out_data  out  DATA_W  pixel intensity.
- out_index  out  ADDR_W  pixel index 0..NUM_PIXELS-1.
- out_last  out  1  high with the final pixel (index NUM_PIXELS-1).
- busy  out  1  high from start acceptance until the scan ends.
- done  out  1  one-cycle pulse after the last pixel is accepted.
- ones_count  out  ADDR_W  number of drawn pixels streamed (see Optional Feature).

Behaviour:
- Reset: FSM to IDLE; idx=0; all outputs 0 (rd_en, rd_addr, out_valid, out_data, out_index, out_last, busy, done, ones_count).
- FSM states: IDLE, FETCH, CAPTURE, SEND, DONE.
- IDLE: start=1 at edge k -> FETCH; idx=0; busy=1 from cycle k+1.
- FETCH (1 cycle): rd_en=1, rd_addr=idx; next state CAPTURE.
- CAPTURE (1 cycle): rd_data sampled into the data register as ON_VALUE/OFF_VALUE; out_index=idx, out_last=(idx==NUM_PIXELS-1); next state SEND.
- SEND: out_valid=1 and outputs held stable until out_valid&&out_ready at an edge.
  - If out_last, go to DONE.
  - Otherwise idx+1 and go to FETCH; out_valid drops in the following cycle.
- DONE (1 cycle): done=1, busy=0, out_valid=0; next state IDLE.
- Latency and throughput: first out_valid is visible in cycle k+3 after start is sampled at edge k. Peak throughput is one pixel per 3 cycles; a full scan with out_ready tied high takes 3*784 = 2352 cycles plus 1 DONE cycle.
- Read port: rd_en is high only in FETCH; rd_addr holds its last value otherwise.
- Start handling: start in any non-IDLE state is ignored. start in the DONE cycle is ignored; a new scan is accepted from IDLE one cycle later.
- Abort: abort=1 in any non-IDLE state -> IDLE at the next edge; out_valid, busy and done are 0 and no done pulse is produced. abort has priority over a simultaneous handshake. abort in IDLE is ignored, and abort with start in IDLE wins, so no scan starts.
- Reset mid-scan behaves like abort but also clears ones_count.
- Arithmetic: idx never exceeds NUM_PIXELS-1; there is no wrap. out_index == rd_addr of the fetch that produced the sample.

Optional Feature:
- Macro: PIXEL_COUNT_EN.
- Defined:
  - ones_count clears to 0 when start is accepted.
  - It increments by 1 on each accepted handshake whose pixel bit was 1.
  - It holds its final value from the DONE cycle until the next accepted start; it holds its partial value after abort.
  - Saturation is unnecessary (max 784 fits ADDR_W=10).
- Not defined: ones_count tied to 0 and no counter logic synthesized; all other behaviour identical.

Test Plan:
- Empty grid, out_ready=1, pulse start:
  - 784 beats, all out_data=0, indices 0..783 in order.
  - out_last only on index 783.
  - done pulses once, 2353 cycles after start sample (3*784 + 1, ±1 for the edge convention).
  - busy low after; ones_count=0.
- Memory with pixels 0, 29 (x=1,y=1) and 783 set:
  - Those beats carry 255, all others 0.
  - ones_count=3 with PIXEL_COUNT_EN, 0 without.
- Backpressure:
  - out_ready low for 10 cycles on beat 5.
  - out_valid/out_data/out_index stay stable throughout; no beat skipped or duplicated; total still 784.
- Abort at beat 100 while out_valid=1 and out_ready=1 at the same edge:
  - Next cycle out_valid=0, busy=0, no done.
  - Subsequent start restarts at index 0.
- start pulsed during an active scan and in the DONE cycle: ignored; exactly one 784-beat scan and one done pulse.
- reset asserted mid-scan at beat 400: all outputs 0 next cycle; FSM in IDLE; rd_en low.
